// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard/forwarding controller for a 3-stage pipeline
// Load-use and multi-cycle stalls, redirect flushes and a trap request/ack handshake.
module hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int NUM_SRC     = 2,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int MCW         = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC*REG_AW-1:0]   rs_i,
  input  logic [NUM_SRC-1:0]          src_used_i,
  input  logic [REG_AW-1:0]           rd_wb_i,
  input  logic                        reg_wr_wb_i,
  input  logic                        wb_is_load_i,
  input  logic                        br_taken_i,
  input  logic                        mc_start_i,
  input  logic [MCW-1:0]              mc_lat_i,
  input  logic                        trap_req_i,
  output logic                        trap_ack_o,
  output logic [2*NUM_SRC-1:0]        forward_o,
  output logic                        stall_s1_o,
  output logic                        stall_s2_o,
  output logic                        flush_s1_o,
  output logic                        flush_s2_o,
  output logic                        busy_o
);

  localparam int LLW = $clog2(LOAD_LAT);
  localparam int FDW = $clog2(FLUSH_DEPTH);
  localparam int CW  = (MCW >= LLW && MCW >= FDW) ? MCW : ((LLW >= FDW) ? LLW : FDW);

  localparam logic [CW-1:0] LD_INIT = CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0] FL_INIT = (FLUSH_DEPTH > 1) ? CW'(FLUSH_DEPTH - 2) : '0;

  typedef enum logic [1:0] {IDLE, LD_STALL, MC_BUSY, FLUSH} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [REG_AW-1:0]   ld_rd_q;

  logic [NUM_SRC-1:0]  match;
  logic [NUM_SRC-1:0]  ld_match;
  logic [2*NUM_SRC-1:0] fwd;
  logic                done;
  logic                accept;
  logic                lu_hit;
  logic                ack;
  logic                mc_long;
  logic                stall;
  logic                br_go;

  always_comb begin
    match    = '0;
    ld_match = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      match[k] = src_used_i[k] & reg_wr_wb_i & (rd_wb_i != '0) &
                 (rs_i[k*REG_AW +: REG_AW] == rd_wb_i);
      ld_match[k] = src_used_i[k] & (rs_i[k*REG_AW +: REG_AW] == ld_rd_q);
    end
  end

  // Requests are only honoured when s2 is not held mid-sequence.
  assign done    = (cnt == '0);
  assign accept  = (state == IDLE) | (((state == LD_STALL) | (state == MC_BUSY)) & done);
  assign lu_hit  = (state == IDLE) & (|match) & wb_is_load_i;
  assign ack     = trap_req_i & accept & ~lu_hit;
  assign mc_long = accept & mc_start_i & ~ack & ~lu_hit & (mc_lat_i >= MCW'(2));
  assign stall   = lu_hit | mc_long |
                   (((state == LD_STALL) | (state == MC_BUSY)) & ~done);
  // A redirect seen while s2 is held is dropped; s2 presents it again later.
  assign br_go   = br_taken_i & accept & ~ack & ~stall;

  always_comb begin
    fwd = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (state == LD_STALL) begin
        fwd[2*k +: 2] = ld_match[k] ? 2'b10 : 2'b00;
      end else if (state != FLUSH) begin
        fwd[2*k +: 2] = (match[k] & ~wb_is_load_i) ? 2'b01 : 2'b00;
      end
    end
  end

  always_comb begin
    trap_ack_o = 1'b0;
    forward_o  = '0;
    stall_s1_o = 1'b0;
    stall_s2_o = 1'b0;
    flush_s1_o = 1'b0;
    flush_s2_o = 1'b0;
    busy_o     = 1'b0;
    if (rst_n) begin
      trap_ack_o = ack;
      forward_o  = fwd;
      stall_s1_o = stall;
      stall_s2_o = stall;
      flush_s1_o = ack | br_go | (state == FLUSH);
      flush_s2_o = ack;
      busy_o     = (state != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ld_rd_q <= '0;
    end else if (state == FLUSH) begin
      if (done) state <= IDLE;
      else      cnt   <= cnt - CW'(1);
    end else if (!accept) begin
      cnt <= cnt - CW'(1);
    end else if (ack | br_go) begin
      cnt   <= FL_INIT;
      state <= (FLUSH_DEPTH > 1) ? FLUSH : IDLE;
    end else if (lu_hit) begin
      ld_rd_q <= rd_wb_i;
      cnt     <= LD_INIT;
      state   <= LD_STALL;
    end else if (mc_long) begin
      cnt   <= CW'(mc_lat_i - MCW'(2));
      state <= MC_BUSY;
    end else begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  rs = '0;
  logic [1:0]  src_used = '0;
  logic [4:0]  rd_wb = '0;
  logic        reg_wr_wb = 1'b0;
  logic        wb_is_load = 1'b0;
  logic        br_taken = 1'b0;
  logic        mc_start = 1'b0;
  logic [5:0]  mc_lat = '0;
  logic        trap_req = 1'b0;
  logic        trap_ack;
  logic [3:0]  forward;
  logic        stall_s1, stall_s2, flush_s1, flush_s2, busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      nm;
    logic [9:0] exp;
  } exp_t;
  exp_t sb[$];

  hazard_ctrl #(
    .REG_AW(5), .NUM_SRC(2), .LOAD_LAT(2), .FLUSH_DEPTH(3), .MCW(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rs_i(rs), .src_used_i(src_used),
    .rd_wb_i(rd_wb), .reg_wr_wb_i(reg_wr_wb), .wb_is_load_i(wb_is_load),
    .br_taken_i(br_taken), .mc_start_i(mc_start), .mc_lat_i(mc_lat),
    .trap_req_i(trap_req), .trap_ack_o(trap_ack), .forward_o(forward),
    .stall_s1_o(stall_s1), .stall_s2_o(stall_s2), .flush_s1_o(flush_s1),
    .flush_s2_o(flush_s2), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // {ack, forward[3:0], stall_s1, stall_s2, flush_s1, flush_s2, busy}
  function automatic logic [9:0] e(input logic ack, input logic [3:0] fw,
                                   input logic st, input logic f1,
                                   input logic f2, input logic bz);
    return {ack, fw, st, st, f1, f2, bz};
  endfunction

  task automatic step(input string nm, input logic rst,
                      input logic [4:0] r1, input logic [4:0] r0,
                      input logic [1:0] used, input logic [4:0] rd,
                      input logic wr, input logic ld, input logic br,
                      input logic mc, input logic [5:0] lat, input logic trap,
                      input logic [9:0] exp);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = rst; rs = {r1, r0}; src_used = used; rd_wb = rd;
    reg_wr_wb = wr; wb_is_load = ld; br_taken = br; mc_start = mc;
    mc_lat = lat; trap_req = trap;
    x.nm = nm;
    x.exp = exp;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      logic [9:0] act;
      x = sb.pop_front();
      act = {trap_ack, forward, stall_s1, stall_s2, flush_s1, flush_s2, busy};
      checks++;
      if (act !== x.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b (ack fwd s1 s2 f1 f2 busy)",
                 x.nm, act, x.exp);
      end
    end
  end

  initial begin
    //         name        rst r1 r0 used rd wr ld br mc lat trap  expected
    step("rst0",      0, 5, 5, 3, 5, 1, 0, 0, 0, 0, 0, e(0, 4'b0000, 0, 0, 0, 0));
    step("rst1",      0, 5, 5, 3, 5, 1, 0, 1, 0, 0, 1, e(0, 4'b0000, 0, 0, 0, 0));
    step("alu_both",  1, 5, 5, 3, 5, 1, 0, 0, 0, 0, 0, e(0, 4'b0101, 0, 0, 0, 0));
    step("alu_x0",    1, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, e(0, 4'b0000, 0, 0, 0, 0));
    step("alu_src0",  1, 3, 5, 3, 5, 1, 0, 0, 0, 0, 0, e(0, 4'b0001, 0, 0, 0, 0));
    step("alu_used1", 1, 5, 5, 2, 5, 1, 0, 0, 0, 0, 0, e(0, 4'b0100, 0, 0, 0, 0));
    step("alu_nowr",  1, 5, 5, 3, 5, 0, 0, 0, 0, 0, 0, e(0, 4'b0000, 0, 0, 0, 0));
    step("lu_det",    1, 2, 7, 3, 7, 1, 1, 0, 0, 0, 0, e(0, 4'b0000, 1, 0, 0, 0));
    step("lu_s1",     1, 2, 7, 3, 0, 0, 0, 0, 0, 0, 0, e(0, 4'b0010, 1, 0, 0, 1));
    step("lu_s2",     1, 2, 7, 3, 0, 0, 0, 0, 0, 0, 0, e(0, 4'b0010, 0, 0, 0, 1));
    step("lu_idle",   1, 2, 7, 3, 0, 0, 0, 0, 0, 0, 0, e(0, 4'b0000, 0, 0, 0, 0));
    step("mul4_go",   1, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, e(0, 4'b0000, 1, 0, 0, 0));
    step("mul4_b1",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 4'b0000, 1, 0, 0, 1));
    step("mul4_b2",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 4'b0000, 1, 0, 0, 1));
    step("mul4_b3",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 4'b0000, 0, 0, 0, 1));
    step("mul4_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 4'b0000, 0, 0, 0, 0));
    step("mul1_go",   1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, e(0, 4'b0000, 0, 0, 0, 0));
    step("mul1_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 4'b0000, 0, 0, 0, 0));
    step("mt_go",     1, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, e(0, 4'b0000, 1, 0, 0, 0));
    step("mt_b1",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e(0, 4'b0000, 1, 0, 0, 1));
    step("mt_b2",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e(0, 4'b0000, 1, 0, 0, 1));
    step("mt_b3",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e(0, 4'b0000, 1, 0, 0, 1));
    step("mt_ack",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e(1, 4'b0000, 0, 1, 1, 1));
    step("mt_f1",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 4'b0000, 0, 1, 0, 1));
    step("mt_f2",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 4'b0000, 0, 1, 0, 1));
    step("mt_idle",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 4'b0000, 0, 0, 0, 0));
    step("br_go",     1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, e(0, 4'b0000, 0, 1, 0, 0));
    step("br_mask",   1, 5, 5, 3, 5, 1, 0, 0, 1, 4, 1, e(0, 4'b0000, 0, 1, 0, 1));
    step("br_f2",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e(0, 4'b0000, 0, 1, 0, 1));
    step("br_ack",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e(1, 4'b0000, 0, 1, 1, 0));
    step("br_tf1",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 4'b0000, 0, 1, 0, 1));
    step("br_tf2",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 4'b0000, 0, 1, 0, 1));
    step("br_idle",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 4'b0000, 0, 0, 0, 0));
    step("rl_det",    1, 0, 7, 1, 7, 1, 1, 1, 0, 0, 0, e(0, 4'b0000, 1, 0, 0, 0));
    step("rl_rst",    0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, e(0, 4'b0000, 0, 0, 0, 0));
    step("rl_det2",   1, 0, 7, 1, 7, 1, 1, 0, 0, 0, 0, e(0, 4'b0000, 1, 0, 0, 0));
    step("rl_s1",     1, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, e(0, 4'b0010, 1, 0, 0, 1));
    step("rl_s2",     1, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, e(0, 4'b0010, 0, 0, 0, 1));
    step("rl_idle",   1, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, e(0, 4'b0000, 0, 0, 0, 0));
    step("tl_det",    1, 0, 7, 1, 7, 1, 1, 0, 0, 0, 1, e(0, 4'b0000, 1, 0, 0, 0));
    step("tl_s1",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e(0, 4'b0000, 1, 0, 0, 1));
    step("tl_ack",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e(1, 4'b0000, 0, 1, 1, 1));
    step("tl_f1",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 4'b0000, 0, 1, 0, 1));
    step("tl_f2",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 4'b0000, 0, 1, 0, 1));
    step("ts_ack",    1, 0, 0, 0, 0, 0, 0, 1, 1, 4, 1, e(1, 4'b0000, 0, 1, 1, 0));
    step("ts_f1",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 4'b0000, 0, 1, 0, 1));
    step("ts_f2",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 4'b0000, 0, 1, 0, 1));
    step("ts_idle",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 4'b0000, 0, 0, 0, 0));
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
